// File: rtl/fixed_weight_loc_gen.sv
// Fixed-weight location generator: rejection-samples random words into WEIGHT distinct
// positions in [0,N), mirrors each accepted position on a write strobe and stores it for readback.
module fixed_weight_loc_gen #(
  parameter string parameter_set = "hqc128",
  parameter int    N          = (parameter_set == "hqc256") ? 57637 :
                                (parameter_set == "hqc192") ? 35851 : 17669,
  parameter int    M          = (parameter_set == "hqc128") ? 15 : 16,
  parameter int    WEIGHT     = (parameter_set == "hqc256") ? 131 :
                                (parameter_set == "hqc192") ? 100 : 66,
  parameter int    LOG_WEIGHT = $clog2(WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           rand_in,
  input  logic                  rand_valid,
  output logic                  rand_ready,
  output logic                  loc_wr_en,
  output logic [LOG_WEIGHT-1:0] loc_wr_addr,
  output logic [M-1:0]          loc_wr_data,
  input  logic                  rd_en,
  input  logic [LOG_WEIGHT-1:0] rd_addr,
  output logic [M-1:0]          rd_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, DONE} state_t;

  localparam logic [M:0]          N_LIMIT    = (M+1)'(N);
  localparam logic [LOG_WEIGHT:0] LAST_COUNT = (LOG_WEIGHT+1)'(WEIGHT - 1);

  state_t                state;
  logic [LOG_WEIGHT:0]   count;
  logic [M-1:0]          cand_reg;
  logic [M-1:0]          cand;
  logic [M-1:0]          loc_mem [WEIGHT];
  logic [WEIGHT-1:0]     match;
  logic                  dup;
  logic                  mem_we;
  logic                  unused_rand;

  assign cand        = rand_in[M-1:0];
  assign unused_rand = ^rand_in[31:M];
  assign rand_ready  = (state == SAMPLE);

  // Only entries already written in this run take part, so stale contents never reject a candidate.
  for (genvar gi = 0; gi < WEIGHT; gi++) begin : g_dup
    assign match[gi] = (count > (LOG_WEIGHT+1)'(gi)) && (loc_mem[gi] == cand_reg);
  end

  assign dup    = |match;
  assign mem_we = !rst && (state == CHECK) && !dup;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      cand_reg    <= '0;
      loc_wr_en   <= 1'b0;
      loc_wr_addr <= '0;
      loc_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      loc_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            busy  <= 1'b1;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (rand_valid && ({1'b0, cand} < N_LIMIT)) begin
            cand_reg <= cand;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (dup) begin
            state <= SAMPLE;
          end else begin
            count       <= count + 1'b1;
            loc_wr_en   <= 1'b1;
            loc_wr_addr <= count[LOG_WEIGHT-1:0];
            loc_wr_data <= cand_reg;
            state       <= (count == LAST_COUNT) ? DONE : SAMPLE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Location store: array is never cleared; read port works in every state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      loc_mem[count[LOG_WEIGHT-1:0]] <= cand_reg;
    end
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= loc_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_fixed_weight_loc_gen.sv
// Directed bench for fixed_weight_loc_gen (hqc128): write stream, rejection,
// duplicate filtering, masking, readback and mid-run reset.
module tb_fixed_weight_loc_gen;

  localparam int M  = 15;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   rand_in = '0;
  logic          rand_valid = 1'b0;
  logic          rand_ready;
  logic          loc_wr_en;
  logic [LW-1:0] loc_wr_addr;
  logic [M-1:0]  loc_wr_data;
  logic          rd_en = 1'b0;
  logic [LW-1:0] rd_addr = '0;
  logic [M-1:0]  rd_data;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int done_cyc_q[$];

  fixed_weight_loc_gen dut (
    .clk(clk), .rst(rst), .start(start), .rand_in(rand_in), .rand_valid(rand_valid),
    .rand_ready(rand_ready), .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr),
    .loc_wr_data(loc_wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (loc_wr_en) begin
      wr_addr_q.push_back(int'(loc_wr_addr));
      wr_data_q.push_back(int'(loc_wr_data));
      wr_cyc_q.push_back(cyc);
      $display("write addr=%0d data=%0d cycle=%0d", loc_wr_addr, loc_wr_data, cyc);
    end
    if (done) begin
      done_cyc_q.push_back(cyc);
      $display("done cycle=%0d", cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("ready_in_sample", int'(rand_ready), 1);
  endtask

  task automatic send(input logic [31:0] w);
    int b = 0;
    rand_in    = w;
    rand_valid = 1'b1;
    while (!rand_ready && b < 20) begin
      tick(1);
      b++;
    end
    if (!rand_ready) chk("send_timeout", 0, 1);
    tick(1);
    rand_valid = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    while (done_cyc_q.size() == 0 && b < 20) begin
      tick(1);
      b++;
    end
    tick(2);
    chk("done_pulses", done_cyc_q.size(), 1);
  endtask

  task automatic check_seq(input string tag, input int n, input int base);
    chk({tag, "_count"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk({tag, "_addr"}, wr_addr_q[i], i);
      chk({tag, "_data"}, wr_data_q[i], base + i);
    end
  endtask

  task automatic rd(input int a, input int exp);
    rd_en   = 1'b1;
    rd_addr = LW'(a);
    tick(1);
    rd_en = 1'b0;
    chk("rd_data", int'(rd_data), exp);
  endtask

  initial begin
    // 1: reset then idle
    do_reset();
    tick(5);
    chk("rst_rand_ready", int'(rand_ready), 0);
    chk("rst_loc_wr_en", int'(loc_wr_en), 0);
    chk("rst_loc_wr_addr", int'(loc_wr_addr), 0);
    chk("rst_loc_wr_data", int'(loc_wr_data), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_no_writes", wr_addr_q.size(), 0);

    // 2: full vector of 0..65
    clear_q();
    do_start();
    for (int i = 0; i < 66; i++) send(32'(i));
    wait_done();
    check_seq("seq0", 66, 0);
    if (wr_cyc_q.size() == 66 && done_cyc_q.size() == 1)
      chk("done_after_last_wr", done_cyc_q[0], wr_cyc_q[65] + 1);
    chk("busy_after_done", int'(busy), 0);
    chk("ready_after_done", int'(rand_ready), 0);
    rd(65, 65);
    rd(0, 0);

    // 3: rejection boundary
    do_reset();
    clear_q();
    do_start();
    send(32'd17669);
    send(32'h0000_FFFF);
    send(32'd17668);
    tick(3);
    chk("rej_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      chk("rej_addr", wr_addr_q[0], 0);
      chk("rej_data", wr_data_q[0], 17668);
    end

    // 4: duplicate filtering
    do_reset();
    clear_q();
    do_start();
    send(32'd100);
    send(32'd100);
    send(32'd200);
    tick(3);
    chk("dup_count", wr_addr_q.size(), 2);
    if (wr_addr_q.size() > 1) begin
      chk("dup_addr0", wr_addr_q[0], 0);
      chk("dup_data0", wr_data_q[0], 100);
      chk("dup_addr1", wr_addr_q[1], 1);
      chk("dup_data1", wr_data_q[1], 200);
    end

    // 5: upper bits masked off
    do_reset();
    clear_q();
    do_start();
    send(32'hFFFF_8005);
    tick(3);
    chk("mask_count", wr_addr_q.size(), 1);
    if (wr_data_q.size() > 0) chk("mask_data", wr_data_q[0], 5);

    // 6: reset mid-run, then values that match the stale array contents
    do_reset();
    clear_q();
    do_start();
    for (int i = 0; i < 10; i++) send(32'(300 + i));
    tick(3);
    chk("pre_rst_count", wr_addr_q.size(), 10);
    do_reset();
    tick(2);
    chk("mid_rst_no_done", done_cyc_q.size(), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(rand_ready), 0);
    clear_q();
    do_start();
    for (int i = 0; i < 66; i++) send(32'(300 + i));
    wait_done();
    check_seq("seq300", 66, 300);
    rd(0, 300);
    rd(65, 365);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
